// File: rtl/mem_backdoor_pkg.sv
// Shared types for the memory backdoor controller: command opcodes, FSM states, default widths.
// The CHECK op is only accepted when MEM_BACKDOOR_CHECK_EN is defined.
package mem_backdoor_pkg;

    localparam int BD_ADDR_WIDTH = 16;
    localparam int BD_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        BD_LOAD  = 2'b00,
        BD_DUMP  = 2'b01,
        BD_CHECK = 2'b10,
        BD_RSVD  = 2'b11
    } bd_op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP_RD,
        DUMP_OUT,
        CHK_RD,
        CHK_CMP,
        DONE
    } bd_state_t;

    // Ops this build can execute; anything else is answered with an err pulse.
    function automatic logic op_supported(bd_op_t op);
        case (op)
            BD_LOAD, BD_DUMP: return 1'b1;
`ifdef MEM_BACKDOOR_CHECK_EN
            BD_CHECK:         return 1'b1;
`endif
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_backdoor_addr_ctr.sv
// Wrapping address register plus remaining-word count for backdoor transfers.
// last flags the final word so the FSM can finish on that beat.
module bd_addr_ctr #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  rem_reg;

    // Address arithmetic deliberately wraps at 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
            rem_reg  <= '0;
        end else if (load) begin
            addr_reg <= base;
            rem_reg  <= len;
        end else if (step) begin
            addr_reg <= addr_reg + ADDR_WIDTH'(1);
            rem_reg  <= rem_reg - LEN_WIDTH'(1);
        end
    end

    assign addr = addr_reg;
    assign last = (rem_reg == LEN_WIDTH'(1));

endmodule

// File: rtl/mem_backdoor.sv
// Backdoor controller between the CPU and memory: holds the CPU off, then loads, dumps or
// checks a memory region. CHECK and its mismatch counters exist only with MEM_BACKDOOR_CHECK_EN.
module mem_backdoor
    import mem_backdoor_pkg::*;
#(
    parameter int ADDR_WIDTH = BD_ADDR_WIDTH,
    parameter int DATA_WIDTH = BD_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  mismatch_cnt,
    output logic [ADDR_WIDTH-1:0] first_mismatch
);

    bd_state_t             state_reg;
    bd_op_t                req_op;
    logic                  done_reg;
    logic                  err_reg;
    logic                  cpu_hold_reg;
    logic                  stall_reg;
    logic [DATA_WIDTH-1:0] hold_data_reg;
    logic                  accept;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  ctr_step;
    logic                  ctr_last;
    logic [ADDR_WIDTH-1:0] ctr_addr;

    assign req_op    = bd_op_t'(cmd_op);
    assign cmd_ready = (state_reg == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    // Gated by reset so no beat lands in memory on the cycle an abort is requested.
    assign wr_ready  = ((state_reg == LOAD) || (state_reg == CHK_RD)) && !reset;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_valid  = (state_reg == DUMP_OUT);
    assign rd_fire   = rd_valid && rd_ready;
    assign ctr_step  = ((state_reg == LOAD) && wr_fire) || rd_fire || (state_reg == CHK_CMP);

    bd_addr_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .base  (cmd_base),
        .len   (cmd_len),
        .step  (ctr_step),
        .addr  (ctr_addr),
        .last  (ctr_last)
    );

    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        if (state_reg != IDLE) begin
            mem_addr  = ctr_addr;
            mem_we    = (state_reg == LOAD) && wr_fire;
            mem_wdata = wr_data;
        end
    end

    // First DUMP_OUT cycle shows the fresh read; a stalled word is replayed from hold_data_reg.
    assign rd_data   = stall_reg ? hold_data_reg : mem_rdata;
    assign cpu_rdata = mem_rdata;
    assign cpu_hold  = cpu_hold_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cpu_hold_reg  <= 1'b0;
            stall_reg     <= 1'b0;
            hold_data_reg <= '0;
        end else begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            stall_reg     <= rd_valid && !rd_ready;
            hold_data_reg <= rd_data;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!op_supported(req_op)) begin
                            err_reg <= 1'b1;
                        end else begin
                            cpu_hold_reg <= 1'b1;
                            if (cmd_len == '0) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                case (req_op)
                                    BD_LOAD: state_reg <= LOAD;
                                    BD_DUMP: state_reg <= DUMP_RD;
                                    default: state_reg <= CHK_RD;
                                endcase
                            end
                        end
                    end
                end
                LOAD: begin
                    if (wr_fire && ctr_last) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DUMP_RD: state_reg <= DUMP_OUT;
                DUMP_OUT: begin
                    if (rd_ready) begin
                        if (ctr_last) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= DUMP_RD;
                        end
                    end
                end
                CHK_RD: begin
                    if (wr_fire) begin
                        state_reg <= CHK_CMP;
                    end
                end
                CHK_CMP: begin
                    if (ctr_last) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= CHK_RD;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    cpu_hold_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MEM_BACKDOOR_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_data_reg;
    logic [LEN_WIDTH-1:0]  mm_cnt_reg;
    logic [ADDR_WIDTH-1:0] first_mm_reg;

    // ctr_addr still points at the compared word during CHK_CMP; it steps on the closing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_data_reg <= '0;
            mm_cnt_reg   <= '0;
            first_mm_reg <= '0;
        end else begin
            if ((state_reg == CHK_RD) && wr_fire) begin
                exp_data_reg <= wr_data;
            end
            if (accept && (req_op == BD_CHECK)) begin
                mm_cnt_reg   <= '0;
                first_mm_reg <= '0;
            end else if ((state_reg == CHK_CMP) && (mem_rdata != exp_data_reg)) begin
                if (mm_cnt_reg == '0) begin
                    first_mm_reg <= ctr_addr;
                end
                mm_cnt_reg <= mm_cnt_reg + LEN_WIDTH'(1);
            end
        end
    end

    assign mismatch_cnt   = mm_cnt_reg;
    assign first_mismatch = first_mm_reg;
`else
    assign mismatch_cnt   = '0;
    assign first_mismatch = '0;
`endif

endmodule

// File: tb/tb_mem_backdoor.sv
// Directed bench for mem_backdoor with a flat-array memory, a reference memory image and a
// per-cycle checker for hold window, bus mux, dump stream ordering and stall stability.
module tb_mem_backdoor;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] mismatch_cnt;
    logic [AW-1:0] first_mismatch;

    always #5 clk = ~clk;

    mem_backdoor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .mismatch_cnt(mismatch_cnt), .first_mismatch(first_mismatch)
    );

    // Memory with registered read, as the real mem block behaves.
    logic [DW-1:0] tb_mem  [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic          mem_clear;
    int            mem_we_cnt = 0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 65536; i++) tb_mem[i] <= '0;
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            mem_we_cnt <= mem_we_cnt + 1;
        end
        mem_rdata <= tb_mem[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Model state: expected hold window and the queue of words a dump must deliver in order.
    logic [DW-1:0] exp_rd_q [$];
    logic [DW-1:0] got_rd_q [$];
    logic [DW-1:0] stim_q   [$];
    bit            exp_hold   = 1'b0;
    bit            tb_armed   = 1'b0;
    bit            cpu_manual = 1'b0;
    bit            prev_stall = 1'b0;
    bit            prev_done  = 1'b0;

    // While the block owns the bus the CPU keeps trying to write 0x5A to 0x0300.
    always @(posedge clk) begin
        #2;
        if (!cpu_manual) begin
            cpu_addr  = 16'h0300;
            cpu_wdata = 8'h5A;
            cpu_we    = exp_hold;
        end
    end

    always @(negedge clk) begin
        if (tb_armed) begin
            chk("cpu_hold", cpu_hold, exp_hold);
            chk("busy", busy, exp_hold);
            chk("cpu_rdata", cpu_rdata, mem_rdata);
            if (!exp_hold) begin
                chk("idle_addr", mem_addr, cpu_addr);
                chk("idle_we", mem_we, cpu_we);
                chk("idle_wdata", mem_wdata, cpu_wdata);
            end
            if (prev_stall) chk("rd_valid_held", rd_valid, 1'b1);
            if (rd_valid) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", rd_valid, 1'b0);
                end else begin
                    chk("rd_data", rd_data, exp_rd_q[0]);
                    if (rd_ready) begin
                        got_rd_q.push_back(rd_data);
                        void'(exp_rd_q.pop_front());
                    end
                end
            end
            if (prev_done) chk("done_one_cycle", done, 1'b0);
            prev_stall = rd_valid && !rd_ready;
            prev_done  = done;
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input logic [3:0] rdy_pat, input bit valid_cmd,
                           output int lat, output logic saw_err);
        int k;
        logic hs;
        logic [AW-1:0] a;
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = len;
        cmd_valid = 1'b1;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        saw_err   = err;
        exp_hold  = valid_cmd;
        if (valid_cmd && op == 2'b01) begin
            for (int i = 0; i < int'(len); i++) exp_rd_q.push_back(ref_mem[16'(int'(base) + i)]);
        end
        a = base;
        lat = 0;
        k = 0;
        while (valid_cmd && !done && lat < 300) begin
            if ((op == 2'b00 || op == 2'b10) && stim_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = stim_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'h00;
            end
            rd_ready = rdy_pat[k % 4];
            hs = wr_valid && wr_ready;
            @(posedge clk);
            if (hs) begin
                if (op == 2'b00) begin
                    ref_mem[a] = stim_q[0];
                    a = a + 16'd1;
                end
                void'(stim_q.pop_front());
            end
            #1;
            lat++;
            k++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        if (valid_cmd) chk("done_timeout", (lat < 300), 1'b1);
        @(posedge clk); #1;
        exp_hold = 1'b0;
        $display("txn op=%0d base=0x%04h len=%0d done_after=%0d err=%0d", op, base, len, lat + 1, saw_err);
    endtask

    int   lat;
    logic saw_err;
    int   we_before;
    int   bad;
    int   exp_mm;
    logic [DW-1:0] chk_exp [4];

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_base = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        cpu_addr = 16'h0300; cpu_we = 1'b0; cpu_wdata = 8'h5A;
        mem_clear = 1'b1;
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        mem_clear = 1'b0;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_cpu_hold", cpu_hold, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_mismatch_cnt", mismatch_cnt, 0);
        chk("rst_first_mismatch", first_mismatch, 0);
        chk("rst_mem_we", mem_we, cpu_we);
        reset = 1'b0;
        tb_armed = 1'b1;
        @(posedge clk); #1;

        // LOAD 4 words back-to-back: done in the 5th cycle after accept.
        stim_q = '{8'hA9, 8'h01, 8'h8D, 8'h00};
        run_cmd(2'b00, 16'h0200, 17'd4, 4'b1111, 1'b1, lat, saw_err);
        chk("load_done_cycle", lat + 1, 5);
        chk("load_mem_0200", tb_mem[16'h0200], 8'hA9);
        chk("load_mem_0201", tb_mem[16'h0201], 8'h01);
        chk("load_mem_0202", tb_mem[16'h0202], 8'h8D);
        chk("load_mem_0203", tb_mem[16'h0203], 8'h00);

        // DUMP with rd_ready toggling 1,0,0,1.
        got_rd_q.delete();
        run_cmd(2'b01, 16'h0200, 17'd4, 4'b1001, 1'b1, lat, saw_err);
        chk("dump_drained", exp_rd_q.size(), 0);
        chk("dump_count", got_rd_q.size(), 4);
        if (got_rd_q.size() == 4) begin
            chk("dump_w0", got_rd_q[0], 8'hA9);
            chk("dump_w1", got_rd_q[1], 8'h01);
            chk("dump_w2", got_rd_q[2], 8'h8D);
            chk("dump_w3", got_rd_q[3], 8'h00);
        end

        // CHECK against a stream with two wrong words.
        chk_exp = '{8'hA9, 8'hFF, 8'h8D, 8'hEE};
        exp_mm = 0;
        for (int i = 0; i < 4; i++) if (ref_mem[16'h0200 + 16'(i)] != chk_exp[i]) exp_mm++;
        chk("model_mm_count", exp_mm, 2);
        stim_q = '{8'hA9, 8'hFF, 8'h8D, 8'hEE};
`ifdef MEM_BACKDOOR_CHECK_EN
        run_cmd(2'b10, 16'h0200, 17'd4, 4'b1111, 1'b1, lat, saw_err);
        chk("check_min_cycles", (lat >= 8), 1'b1);
        chk("check_mismatch_cnt", mismatch_cnt, exp_mm);
        chk("check_first_mismatch", first_mismatch, 16'h0201);
`else
        run_cmd(2'b10, 16'h0200, 17'd4, 4'b1111, 1'b0, lat, saw_err);
        chk("check_rejected_err", saw_err, 1'b1);
        chk("check_off_mismatch_cnt", mismatch_cnt, 0);
        chk("check_off_first_mismatch", first_mismatch, 0);
        stim_q.delete();
`endif

        // LOAD that wraps the address space, then dump it back with rd_ready high.
        stim_q = '{8'h11, 8'h22};
        run_cmd(2'b00, 16'hFFFF, 17'd2, 4'b1111, 1'b1, lat, saw_err);
        chk("wrap_mem_ffff", tb_mem[16'hFFFF], 8'h11);
        chk("wrap_mem_0000", tb_mem[16'h0000], 8'h22);
        got_rd_q.delete();
        run_cmd(2'b01, 16'hFFFF, 17'd2, 4'b1111, 1'b1, lat, saw_err);
        chk("dump_fast_done_cycle", lat + 1, 5);
        chk("dump_fast_count", got_rd_q.size(), 2);
        if (got_rd_q.size() == 2) begin
            chk("dump_fast_w0", got_rd_q[0], 8'h11);
            chk("dump_fast_w1", got_rd_q[1], 8'h22);
        end

        // Reserved op: err pulse only, CPU never held.
        we_before = mem_we_cnt;
        run_cmd(2'b11, 16'h0200, 17'd4, 4'b1111, 1'b0, lat, saw_err);
        chk("rsvd_err", saw_err, 1'b1);
        chk("rsvd_err_pulse", err, 1'b0);
        chk("rsvd_no_write", mem_we_cnt, we_before);

        // Zero-length LOAD: done in the cycle right after accept, nothing written.
        we_before = mem_we_cnt;
        run_cmd(2'b00, 16'h0500, 17'd0, 4'b1111, 1'b1, lat, saw_err);
        chk("len0_done_cycle", lat + 1, 1);
        chk("len0_no_write", mem_we_cnt, we_before);

        // Reset after the 2nd beat of a 4-word LOAD.
        cmd_op = 2'b00; cmd_base = 16'h0200; cmd_len = 17'd4; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_hold = 1'b1;
        wr_valid = 1'b1; wr_data = 8'hC1;
        @(posedge clk); #1;
        wr_data = 8'hC2;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        ref_mem[16'h0200] = 8'hC1;
        ref_mem[16'h0201] = 8'hC2;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_hold = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_cpu_hold", cpu_hold, 1'b0);
        chk("abort_done", done, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_done_late", done, 1'b0);
        chk("abort_mem_0200", tb_mem[16'h0200], 8'hC1);
        chk("abort_mem_0201", tb_mem[16'h0201], 8'hC2);
        chk("abort_mem_0202", tb_mem[16'h0202], 8'h8D);
        chk("abort_mem_0203", tb_mem[16'h0203], 8'h00);
        $display("txn op=0 base=0x0200 len=4 aborted_by_reset");

        // CPU write and read pass straight through while idle.
        cpu_manual = 1'b1;
        cpu_addr = 16'h0400; cpu_wdata = 8'h77; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0;
        ref_mem[16'h0400] = 8'h77;
        @(posedge clk); #1;
        chk("cpu_pass_rdata", cpu_rdata, 8'h77);
        $display("txn cpu write/read addr=0x0400 data=0x%02h", cpu_rdata);
        cpu_manual = 1'b0;
        @(posedge clk); #1;

        chk("cpu_blocked_0300", tb_mem[16'h0300], 8'h00);
        bad = 0;
        for (int i = 0; i < 65536; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_backdoor.md
# mem_backdoor

Synthesizable backdoor controller between `cpu_top` and `mem`, replacing the bench-only flat-array override path. Holds the CPU off the bus, then streams firmware into memory, streams regions out for dumps, or compares memory against an expected stream, counting mismatches. Parametrised in address/data width so the same block serves the 6502 bus and wider future buses.

## Interface
- ADDR_WIDTH, 16: bus and memory address width.
- DATA_WIDTH, 8: data word width.
- LEN_WIDTH, ADDR_WIDTH+1: transfer length width; allows a full-space transfer.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_op  in  2  00 LOAD, 01 DUMP, 10 CHECK, 11 reserved.
- cmd_base  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  word count.
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  input stream: load data or expected data.
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_WIDTH  dump output stream.
- cpu_addr, cpu_we, cpu_wdata  in  ADDR_WIDTH, 1, DATA_WIDTH  CPU bus request.
- cpu_rdata  out  DATA_WIDTH  returns mem_rdata.
- mem_addr, mem_we, mem_wdata  out  ADDR_WIDTH, 1, DATA_WIDTH  memory port.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr.
- cpu_hold  out  1  drives the CPU rdy low while high.
- busy, done, err  out  1 each  status; done and err are one-cycle pulses.
- mismatch_cnt  out  LEN_WIDTH  CHECK mismatches.
- first_mismatch  out  ADDR_WIDTH  address of first CHECK mismatch.

## Operation
- States: IDLE, LOAD, DUMP_RD, DUMP_OUT, CHK_RD, CHK_CMP, DONE.
- cmd_ready = (state==IDLE) && !reset. On accept, the block latches base, len and op.
- len==0 goes straight to DONE. Reserved op, or CHECK when compiled out, pulses err for one cycle and stays in IDLE.
- In IDLE the mux passes the CPU through: mem_* = cpu_*. Otherwise mem_* is driven internally and mem_we from the CPU is blocked.
- LOAD: wr_ready=1. Each wr handshake writes wr_data at the current address, then increments the address and the count. After the len-th beat, go to DONE.
- DUMP: DUMP_RD issues a read. DUMP_OUT asserts rd_valid with the read data, registered, holding it stable until rd_ready. After the handshake, go to DUMP_RD, or to DONE after len words.
- CHECK: CHK_RD has wr_ready=1. On a beat it latches the expected word and issues a read. CHK_CMP compares mem_rdata. On inequality it increments mismatch_cnt; on the first mismatch it also loads first_mismatch. Then go to CHK_RD, or to DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH: base 0xFFFF with len 2 touches 0xFFFF then 0x0000.
- mismatch_cnt and first_mismatch clear on accepting a new CHECK and hold otherwise.
- DONE lasts exactly one cycle: done=1, then IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: cpu_hold 0, busy 0, done 0, err 0, rd_valid 0, wr_ready 0, mismatch_cnt 0, first_mismatch 0, mem_we passes cpu_we, state IDLE.
- cpu_hold rises the cycle after command accept and falls the cycle after DONE.
- LOAD throughput is one word per cycle. DUMP and CHECK take at least 2 cycles per word.
- Command accepted at cycle t:
  - LOAD of N words with back-to-back data: done at t+N+1.
  - DUMP with rd_ready tied high: done at t+2N+1.
- rd_valid never drops without a handshake. rd_data is stable while rd_valid && !rd_ready.
- A reset asserted mid-operation returns to IDLE the next cycle and drops cpu_hold. Words already written stay in memory. No done pulse is produced.
- cmd_valid while busy is ignored: it is not queued.

## Configuration
- MEM_BACKDOOR_CHECK_EN defined: the CHECK op, mismatch_cnt and first_mismatch are built.
- Not defined: CHECK is rejected with err, and mismatch_cnt and first_mismatch are tied to 0.

## Structure
- Shared package additions:
  - `bd_op_t` enum with BD_LOAD, BD_DUMP, BD_CHECK, BD_RSVD.
  - `bd_state_t` enum.
  - Default width macros reuse `ADDR_WIDTH` / `REG_WIDTH`.
- One sub-module is natural: `bd_addr_ctr`, holding the wrapping address register and remaining-count register with load/step/last outputs.
- The bus mux and FSM stay in `mem_backdoor`.

## Test plan
- LOAD base 0x0200, len 4, data 0xA9,0x01,0x8D,0x00 back-to-back: memory at 0x0200–0x0203 holds those bytes, done at accept+5, cpu_hold high for exactly that window.
- DUMP base 0x0200, len 4, rd_ready toggling 1,0,0,1…: rd_data sequence 0xA9,0x01,0x8D,0x00 with no drops or duplicates, and rd_data stable while stalled.
- CHECK base 0x0200, len 4, expected 0xA9,0xFF,0x8D,0xEE: mismatch_cnt=2, first_mismatch=0x0201, done pulse.
- LOAD base 0xFFFF, len 2, data 0x11,0x22: mem[0xFFFF]=0x11, mem[0x0000]=0x22.
- Reset asserted after the 2nd beat of a 4-word LOAD: next cycle state is IDLE with cpu_hold=0 and no done. mem[0x0200..0x0201] are written and the remaining addresses are unchanged.
- cmd_op=11 and len=0 cases: the reserved op gives an err pulse with no cpu_hold. len=0 LOAD gives done at accept+1 with no memory write.
